multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised multi-channel clock divider and tick generator. It produces NUM_CH independent square-wave outputs and one-cycle tick strobes from the system clock. Each channel's half-period is programmable at run time and is shared between display blink, seconds counting and debounce sampling logic. It also supports global enable/pause and a synchronous phase clear that keeps the programmed divisors.

## Interface
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 32, width of per-channel counter and half-period register
- CH_W, 2, width of channel-select bus; 2**CH_W >= NUM_CH required
- DEFAULT_HALF, 1, half-period value loaded into every channel at reset

- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clock clk
- enable  input  1  global run; low = all counters hold (pause)
- clear  input  1  synchronous phase restart; divisors retained
- load  input  1  one-cycle strobe: write load_val to channel load_ch
- load_ch  input  CH_W  target channel for load
- load_val  input  CNT_W  new half-period value (unsigned)
- sq  output  NUM_CH  per-channel square wave, registered
- tick  output  NUM_CH  per-channel one-cycle pulse coincident with each sq toggle, registered

## Operation
- Per channel i: half[i] (CNT_W), cnt[i] (CNT_W), sq[i], tick[i].
- Reset: half[i]=DEFAULT_HALF, cnt[i]=0, sq[i]=1, tick[i]=0 for all i.
- Priority per cycle: reset > clear > load > counting.
- clear=1: cnt[i]=0, sq[i]=1, tick[i]=0 for all i; half[] unchanged; load in the same cycle is ignored.
- load=1 with load_ch < NUM_CH: half[load_ch] <= load_val, cnt[load_ch] <= 0, tick[load_ch] <= 0, sq[load_ch] held. That channel does not count this cycle. Other channels count normally.
- load=1 with load_ch >= NUM_CH: write ignored; all channels count normally.
- Counting (enable=1): if cnt[i] >= half[i], then sq[i] toggles, tick[i]=1, cnt[i]=0. Otherwise cnt[i]=cnt[i]+1, tick[i]=0.
- The comparison is >=, not ==. If half is lowered below the current count by any path, the channel toggles on the next enabled edge and never runs through wrap-around.
- cnt[i] never exceeds max(half[i], previous cnt); no modular overflow is possible.
- enable=0: cnt and sq hold; tick forced 0. load and clear still act while paused.
- half[i]=0: sq[i] toggles every enabled cycle and tick[i] is held high continuously.

## Timing
- sq period = 2*(half+1) enabled clk cycles; duty 50%.
- After reset deasserts with enable=1: first sq toggle and tick land on the (half+1)th rising edge after the reset edge.
- tick and sq change on the same edge; both come from registers, with no combinational path from inputs to outputs.
- After load on channel c with enable=1: the first toggle lands on the (load_val+1)th edge after the load edge.
- After clear: every channel restarts in phase alignment, sq=1; first toggles occur at (half[i]+1) edges.
- Pause/resume: resuming continues from the held cnt. Total enabled cycles between toggles is unchanged.
- Reset mid-operation overrides everything, including a pending load; half[] returns to DEFAULT_HALF.

## Test plan
- Reset then enable=1, defaults (half=1): each sq reads 1,1,0,0,1,1... per cycle, giving a period of 4. tick pulses on edges 2, 4, 6 after reset.
- load ch2 with load_val=4 while running: sq[2] toggles first at 5 edges after load, then every 5 edges (period 10). Other channels show no phase disturbance.
- Lower half below current count: half=9, let cnt reach 7, then load ch0 with load_val=3 (resets cnt). Separately, check that the >= path toggles on the next edge when the count exceeds half.
- enable held low for 7 cycles mid-count: sq and cnt frozen, tick=0; after resume, the toggle lands exactly 7 cycles later than unpaused.
- clear asserted together with load and enable: all sq=1, cnt=0, half unchanged (load ignored). load_ch=5 with NUM_CH=4 leaves all half[] unchanged.
- load_val=0 on ch1: sq[1] toggles every cycle and tick[1] stays 1. Reset asserted mid-period: outputs are sq=all 1 and tick=0 on the next edge, with half restored to DEFAULT_HALF.

Source files
------------

// File: rtl/multi_clock_divider.sv
// Multi-channel clock divider / tick generator.
// Each channel produces a 50% duty square wave with a programmable half-period
// and a one-cycle tick coincident with every square-wave edge.
module multi_clock_divider #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned DEFAULT_HALF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_val,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  // Channel select widened so out-of-range selects simply never match a channel.
  logic [31:0] load_idx;
  assign load_idx = 32'(load_ch);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sq_q;
    logic             tick_q;
    logic             sel;
    logic             hit;

    assign sel = load && (load_idx == 32'(g));
    // >= rather than == so a count left above a lowered half-period toggles
    // immediately instead of running through wrap-around.
    assign hit = (cnt_q >= half_q);

    // Per-channel divider state: reset > clear > load > counting.
    always_ff @(posedge clk) begin
      if (reset) begin
        half_q <= DEF_HALF;
        cnt_q  <= '0;
        sq_q   <= 1'b1;
        tick_q <= 1'b0;
      end else if (clear) begin
        cnt_q  <= '0;
        sq_q   <= 1'b1;
        tick_q <= 1'b0;
      end else if (sel) begin
        half_q <= load_val;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (enable) begin
        if (hit) begin
          cnt_q  <= '0;
          sq_q   <= ~sq_q;
          tick_q <= 1'b1;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign sq[g]   = sq_q;
    assign tick[g] = tick_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomized self-checking bench for multi_clock_divider with a behavioural
// model that tracks enabled edges since each channel's last toggle/restart.
module tb_multi_clock_divider;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned SW  = 3;
  localparam int unsigned DH  = 1;

  logic          clk = 1'b0;
  logic          reset, enable, clear, load;
  logic [SW-1:0] load_ch;
  logic [CW-1:0] load_val;
  logic [NCH-1:0] sq, tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  longint  m_half  [NCH];
  longint  m_since [NCH];
  bit      m_sq    [NCH];
  bit      m_tick  [NCH];

  multi_clock_divider #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .CH_W(SW),
    .DEFAULT_HALF(DH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .clear(clear),
    .load(load),
    .load_ch(load_ch),
    .load_val(load_val),
    .sq(sq),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // One rising edge of behaviour: a channel toggles once half+1 enabled
  // edges have elapsed since it last toggled or restarted.
  task automatic model_edge();
    for (int i = 0; i < int'(NCH); i++) begin
      if (reset) begin
        m_half[i] = DH; m_since[i] = 0; m_sq[i] = 1; m_tick[i] = 0;
      end else if (clear) begin
        m_since[i] = 0; m_sq[i] = 1; m_tick[i] = 0;
      end else if (load && int'(load_ch) == i) begin
        m_half[i] = longint'(load_val); m_since[i] = 0; m_tick[i] = 0;
      end else if (enable) begin
        m_since[i] = m_since[i] + 1;
        if (m_since[i] >= m_half[i] + 1) begin
          m_since[i] = 0; m_sq[i] = !m_sq[i]; m_tick[i] = 1;
        end else begin
          m_tick[i] = 0;
        end
      end else begin
        m_tick[i] = 0;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_sq();
    logic [NCH-1:0] v;
    for (int i = 0; i < int'(NCH); i++) v[i] = m_sq[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] v;
    for (int i = 0; i < int'(NCH); i++) v[i] = m_tick[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("sq", 64'(sq), 64'(exp_sq()));
    check("tick", 64'(tick), 64'(exp_tick()));
    load = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_load(input int ch, input int val);
    load = 1'b1; load_ch = SW'(ch); load_val = CW'(val);
    step();
  endtask

  initial begin
    for (int i = 0; i < int'(NCH); i++) begin
      m_half[i] = 0; m_since[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
    end
    reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
    load_ch = '0; load_val = '0;
    #1;
    step(); step();
    check("reset_sq", 64'(sq), 64'hF);
    check("reset_tick", 64'(tick), 64'h0);

    // Defaults: half=1, period 4, ticks on edges 2,4,6
    reset = 1'b0; enable = 1'b1;
    step(); check("def_e1_sq", 64'(sq), 64'hF); check("def_e1_tick", 64'(tick), 64'h0);
    step(); check("def_e2_sq", 64'(sq), 64'h0); check("def_e2_tick", 64'(tick), 64'hF);
    step(); check("def_e3_sq", 64'(sq), 64'h0); check("def_e3_tick", 64'(tick), 64'h0);
    step(); check("def_e4_sq", 64'(sq), 64'hF); check("def_e4_tick", 64'(tick), 64'hF);

    // Load ch2 with 4: first toggle 5 edges later, then every 5
    do_load(2, 4);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("ld2_tick", 64'(tick[2]), 64'((k % 5) == 0));
    end

    // Pause for 7 cycles: ticks forced low, state frozen
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("pause_tick", 64'(tick), 64'h0);
    end
    enable = 1'b1;
    for (int k = 0; k < 12; k++) step();

    // Clear together with load and enable: load ignored, all phases restart
    clear = 1'b1; load = 1'b1; load_ch = 3'd0; load_val = 32'd20;
    step();
    check("clr_sq", 64'(sq), 64'hF);
    check("clr_tick", 64'(tick), 64'h0);
    // ch2 still has half=4 (not disturbed), ch0 still half=1 (load ignored)
    step(); step();
    check("clr_ch0_tick", 64'(tick[0]), 64'h1);

    // Out-of-range channel select
    do_load(5, 0);
    for (int k = 0; k < 10; k++) step();

    // half=0 on ch1: toggles every cycle, tick held high
    do_load(1, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("h0_tick1", 64'(tick[1]), 64'h1);
    end

    // ch0 half=9, run 7 edges, then reload with 3
    do_load(0, 9);
    for (int k = 0; k < 7; k++) step();
    do_load(0, 3);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("ld0_tick", 64'(tick[0]), 64'((k % 4) == 0));
    end

    // Reset mid-period
    reset = 1'b1;
    step();
    check("rst_mid_sq", 64'(sq), 64'hF);
    check("rst_mid_tick", 64'(tick), 64'h0);
    reset = 1'b0;
    step(); step();
    check("rst_def_tick", 64'(tick), 64'hF);

    // Randomized run
    for (int k = 0; k < 3000; k++) begin
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 99) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      load     = ($urandom_range(0, 14) == 0);
      load_ch  = SW'($urandom_range(0, 7));
      load_val = CW'($urandom_range(0, 12));
      step();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
